// File: rtl/bias_bank_add_if.sv
// Bus bundle for bias_bank_add: bias load port, accumulator input stream,
// result output stream and the sticky status flags.
//   master : the side that loads biases, sends vectors and takes results
//   slave  : the bias_bank_add block itself
// Lane i of every vector occupies bits [W*(i+1)-1 : W*i].
interface bias_bank_add_if #(
  parameter int N_adder_tree = 16,
  parameter int W            = 18,
  parameter int N_GROUPS     = 64
);
  localparam int G_W = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

  logic                      ld_en;
  logic [G_W-1:0]            ld_group;
  logic [N_adder_tree*W-1:0] ld_data;

  logic                      in_valid;
  logic                      in_ready;
  logic [G_W-1:0]            in_group;
  logic                      in_relu;
  logic [N_adder_tree*W-1:0] in_data;

  logic                      out_valid;
  logic                      out_ready;
  logic [N_adder_tree*W-1:0] out_data;

  logic                      sat_flag;
  logic                      grp_err;
  logic                      flag_clr;

  modport master (
    output ld_en, ld_group, ld_data,
    output in_valid, in_group, in_relu, in_data,
    output out_ready, flag_clr,
    input  in_ready, out_valid, out_data, sat_flag, grp_err
  );

  modport slave (
    input  ld_en, ld_group, ld_data,
    input  in_valid, in_group, in_relu, in_data,
    input  out_ready, flag_clr,
    output in_ready, out_valid, out_data, sat_flag, grp_err
  );
endinterface

// File: rtl/bias_bank_add.sv
// Runtime-loadable bias bank: holds N_GROUPS bias vectors and adds the
// selected group's biases to one accumulator vector per transaction, with
// per-lane signed saturation and optional ReLU. Two-stage pipeline
// (S1 = operand capture, S2 = add/saturate/result) with valid/ready on both
// sides; loads never stall.
// Ports:
//   clk   - clock, all logic on the rising edge
//   rst_n - synchronous active-low reset
//   bus   - bias_bank_add_if.slave (load port, input/output streams, flags)
module bias_bank_add #(
  parameter int N_adder_tree = 16,
  parameter int W            = 18,
  parameter int N_GROUPS     = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  bias_bank_add_if.slave bus
);
  localparam int G_W   = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int NW    = N_adder_tree * W;
  localparam int DEPTH = 2 ** G_W;
  localparam logic [G_W:0] GRP_LIMIT = (G_W + 1)'(N_GROUPS);
  localparam logic [W-1:0] SAT_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN   = {1'b1, {(W-1){1'b0}}};

  // Bias storage; a group only contributes once its loaded bit is set.
  logic [NW-1:0]    ram [DEPTH];
  logic [DEPTH-1:0] loaded;

  logic          ld_ok, in_ok;
  logic          s2_adv, in_ready, accept;
  logic [NW-1:0] bias_rd;

  logic          s1_valid, s1_relu;
  logic [NW-1:0] s1_data, s1_bias;

  logic          out_valid_q;
  logic [NW-1:0] out_data_q;
  logic          sat_q, grp_q;

  logic [NW-1:0] result;
  logic          lane_sat;

  assign ld_ok = {1'b0, bus.ld_group} < GRP_LIMIT;
  assign in_ok = {1'b0, bus.in_group} < GRP_LIMIT;

  // S1 moves into S2 under the same condition that lets S2 advance.
  assign s2_adv   = !out_valid_q || bus.out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = bus.in_valid && in_ready;

  // Asynchronous read of the pre-edge contents: a load to the same group in
  // the accept cycle lands at the edge and is seen by the next transaction.
  assign bias_rd = (in_ok && loaded[bus.in_group]) ? ram[bus.in_group] : '0;

  // NOTE: the bias RAM is deliberately left out of reset; the loaded bits
  // mask stale contents, which keeps the array a plain memory.
  always_ff @(posedge clk) begin
    if (bus.ld_en && ld_ok) ram[bus.ld_group] <= bus.ld_data;
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loaded <= '0;
    end else if (bus.ld_en && ld_ok) begin
      loaded[bus.ld_group] <= 1'b1;
    end
  end

  // S1: valid bit is reset; the captured operands are plain datapath regs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_data <= bus.in_data;
      s1_bias <= bias_rd;
      s1_relu <= bus.in_relu;
    end
  end

  // NOTE: every variable driven here gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    logic [W-1:0] a, b, r;
    logic [W:0]   s;
    result   = '0;
    lane_sat = 1'b0;
    a = '0;
    b = '0;
    r = '0;
    s = '0;
    for (int i = 0; i < N_adder_tree; i++) begin
      a = s1_data[i*W +: W];
      b = s1_bias[i*W +: W];
      s = {a[W-1], a} + {b[W-1], b};
      // Top two bits disagree only when the W-bit result overflowed.
      if (s[W] != s[W-1]) begin
        r        = s[W] ? SAT_MIN : SAT_MAX;
        lane_sat = 1'b1;
      end else begin
        r = s[W-1:0];
      end
      if (s1_relu && r[W-1]) r = '0;
      result[i*W +: W] = r;
    end
  end

  // S2: holds its result while out_valid && !out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) out_data_q <= result;
    end
  end

  // Sticky flags; a set event in the clear cycle wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
      grp_q <= 1'b0;
    end else begin
      sat_q <= (sat_q && !bus.flag_clr) || (s2_adv && s1_valid && lane_sat);
      grp_q <= (grp_q && !bus.flag_clr) || (accept && !in_ok);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.sat_flag  = sat_q;
  assign bus.grp_err   = grp_q;
endmodule
